postage_deadlock_report_ctrl: RTL and testbench

Supervisor for the postage deadlock monitor. It qualifies the monitor's per-cycle block flag with a persistence threshold. On a confirmed deadlock it snapshots which AXIS channels are blocked and reports each blocked channel in sequence over a valid/ready stream. It then holds the deadlock indication until software clears it. It sits between the monitor outputs and the debug/status register path.

---
 rtl/postage_deadlock_report_ctrl_if.sv | 24 ++
 rtl/postage_deadlock_report_ctrl.sv | 136 +++++++++++++
 tb/tb_postage_deadlock_report_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/postage_deadlock_report_ctrl_if.sv
// Report stream between the deadlock supervisor and the debug/status sink.
// One beat per blocked channel; rpt_last marks the final beat of a report.
interface postage_deadlock_report_ctrl_if #(
  parameter int CH_W = 4
);
  logic            rpt_valid;
  logic            rpt_ready;
  logic [CH_W-1:0] rpt_chan;
  logic            rpt_last;

  modport master (
    output rpt_valid,
    output rpt_chan,
    output rpt_last,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_chan,
    input  rpt_last,
    output rpt_ready
  );
endinterface

// File: rtl/postage_deadlock_report_ctrl.sv
// Deadlock supervisor: qualifies the monitor block flag by persistence, snapshots
// blocked channels, streams one report beat per channel, then holds until cleared.
module postage_deadlock_report_ctrl #(
  parameter int NUM_CH = 10,
  parameter int CH_W   = 4,
  parameter int THRESH = 1024,
  parameter int CNT_W  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       block_in,
  input  logic [NUM_CH*NUM_CH-1:0]   block_info_in,
  input  logic                       clear,
  output logic                       deadlock,
  output logic [NUM_CH-1:0]          blocked_mask,
  output logic [7:0]                 event_count,
  postage_deadlock_report_ctrl_if.master rpt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_REPORT,
    ST_HOLD
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_CH-1:0] MASK_ONE = NUM_CH'(1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_CH-1:0]  work_mask_q;
  logic [NUM_CH-1:0]  blocked_mask_q;
  logic               deadlock_q;
  logic               rpt_valid_q;
  logic [7:0]         event_count_q;

  logic [NUM_CH-1:0]  snap_d;
  logic [NUM_CH-1:0]  work_mask_d;
  logic [CH_W-1:0]    lowest_chan;

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    snap_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      snap_d[i] = |block_info_in[i*NUM_CH +: NUM_CH];
    end
  end

  // Clearing the lowest set bit retires the beat currently being presented.
  assign work_mask_d = work_mask_q & (work_mask_q - MASK_ONE);

  // An empty working mask encodes to the "no channel identified" sentinel.
  always_comb begin
    lowest_chan = CH_W'(NUM_CH);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (work_mask_q[i]) lowest_chan = CH_W'(i);
    end
  end

  // NOTE: reset is synchronous and active-low; state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      work_mask_q    <= '0;
      blocked_mask_q <= '0;
      deadlock_q     <= 1'b0;
      rpt_valid_q    <= 1'b0;
      event_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && block_in && !clear) begin
            state_q <= ST_ARMED;
            cnt_q   <= CNT_ONE;
          end
        end

        ST_ARMED: begin
          if (clear || !enable || !block_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q        <= ST_REPORT;
            cnt_q          <= '0;
            deadlock_q     <= 1'b1;
            blocked_mask_q <= snap_d;
            work_mask_q    <= snap_d;
            rpt_valid_q    <= 1'b1;
            if (event_count_q != 8'hFF) event_count_q <= event_count_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_REPORT: begin
          if (clear) begin
            state_q        <= ST_IDLE;
            rpt_valid_q    <= 1'b0;
            deadlock_q     <= 1'b0;
            blocked_mask_q <= '0;
            work_mask_q    <= '0;
          end else if (rpt.rpt_ready) begin
            work_mask_q <= work_mask_d;
            if (work_mask_d == '0) begin
              state_q     <= ST_HOLD;
              rpt_valid_q <= 1'b0;
            end
          end
        end

        ST_HOLD: begin
          if (clear) begin
            state_q        <= ST_IDLE;
            deadlock_q     <= 1'b0;
            blocked_mask_q <= '0;
            work_mask_q    <= '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign deadlock      = deadlock_q;
  assign blocked_mask  = blocked_mask_q;
  assign event_count   = event_count_q;
  assign rpt.rpt_valid = rpt_valid_q;
  assign rpt.rpt_chan  = rpt_valid_q ? lowest_chan : '0;
  assign rpt.rpt_last  = rpt_valid_q && (work_mask_d == '0);

endmodule

// File: tb/tb_postage_deadlock_report_ctrl.sv
// Directed bench for the deadlock supervisor with THRESH reduced to 8.
// Expected values are hand-derived; an event-count model tracks detections.
module tb_postage_deadlock_report_ctrl;

  localparam int NUM_CH = 10;
  localparam int CH_W   = 4;
  localparam int THRESH = 8;
  localparam int CNT_W  = 16;

  logic                     clock;
  logic                     reset;
  logic                     enable;
  logic                     block_in;
  logic [NUM_CH*NUM_CH-1:0] block_info_in;
  logic                     clear;
  logic                     deadlock;
  logic [NUM_CH-1:0]        blocked_mask;
  logic [7:0]               event_count;

  postage_deadlock_report_ctrl_if #(.CH_W(CH_W)) rif ();

  postage_deadlock_report_ctrl #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .THRESH(THRESH), .CNT_W(CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .block_in      (block_in),
    .block_info_in (block_info_in),
    .clear         (clear),
    .deadlock      (deadlock),
    .blocked_mask  (blocked_mask),
    .event_count   (event_count),
    .rpt           (rif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;
  int exp_events;
  logic [NUM_CH*NUM_CH-1:0] info_259;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic detect(input logic [NUM_CH*NUM_CH-1:0] info);
    enable        = 1'b1;
    clear         = 1'b0;
    block_info_in = info;
    block_in      = 1'b1;
    repeat (THRESH) step();
    block_in      = 1'b0;
    block_info_in = '0;
    if (exp_events < 255) exp_events++;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    if (deadlock !== 1'b0) begin $display("FAIL reset.deadlock got %0b exp 0", deadlock); miscompares++; end
    vectors++;
    if (blocked_mask !== 10'h000) begin $display("FAIL reset.mask got %h exp 000", blocked_mask); miscompares++; end
    vectors++;
    if (rif.rpt_valid !== 1'b0) begin $display("FAIL reset.valid got %0b exp 0", rif.rpt_valid); miscompares++; end
    vectors++;
    if (rif.rpt_chan !== 4'd0) begin $display("FAIL reset.chan got %0d exp 0", rif.rpt_chan); miscompares++; end
    vectors++;
    if (rif.rpt_last !== 1'b0) begin $display("FAIL reset.last got %0b exp 0", rif.rpt_last); miscompares++; end
    vectors++;
    if (event_count !== 8'd0) begin $display("FAIL reset.events got %0d exp 0", event_count); miscompares++; end
    vectors++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_persistence();
    enable        = 1'b1;
    block_info_in = info_259;
    block_in      = 1'b1;
    for (int k = 1; k <= THRESH - 1; k++) begin
      step();
      if (deadlock !== 1'b0) begin $display("FAIL persist.short%0d got %0b exp 0", k, deadlock); miscompares++; end
      vectors++;
    end
    block_in = 1'b0;
    step();
    if (deadlock !== 1'b0) begin $display("FAIL persist.gap got %0b exp 0", deadlock); miscompares++; end
    vectors++;
    block_in = 1'b1;
    for (int k = 1; k <= THRESH - 1; k++) begin
      step();
      if (deadlock !== 1'b0) begin $display("FAIL persist.run%0d got %0b exp 0", k, deadlock); miscompares++; end
      vectors++;
    end
    step();
    block_in = 1'b0;
    exp_events++;
    if (deadlock !== 1'b1) begin $display("FAIL persist.rise got %0b exp 1", deadlock); miscompares++; end
    vectors++;
    if (event_count !== 8'(exp_events)) begin $display("FAIL persist.events got %0d exp %0d", event_count, exp_events); miscompares++; end
    vectors++;
    pulse_clear();
    if (deadlock !== 1'b0) begin $display("FAIL persist.clear got %0b exp 0", deadlock); miscompares++; end
    vectors++;
  endtask

  task automatic test_clear_priority();
    enable   = 1'b1;
    block_in = 1'b1;
    repeat (THRESH - 1) step();
    clear = 1'b1;
    step();
    clear    = 1'b0;
    block_in = 1'b0;
    if (deadlock !== 1'b0) begin $display("FAIL clrprio.deadlock got %0b exp 0", deadlock); miscompares++; end
    vectors++;
    if (rif.rpt_valid !== 1'b0) begin $display("FAIL clrprio.valid got %0b exp 0", rif.rpt_valid); miscompares++; end
    vectors++;
    if (event_count !== 8'(exp_events)) begin $display("FAIL clrprio.events got %0d exp %0d", event_count, exp_events); miscompares++; end
    vectors++;
    step();
    if (deadlock !== 1'b0) begin $display("FAIL clrprio.later got %0b exp 0", deadlock); miscompares++; end
    vectors++;
  endtask

  task automatic test_multi_channel();
    rif.rpt_ready = 1'b1;
    detect(info_259);
    if (blocked_mask !== 10'h224) begin $display("FAIL multi.mask got %h exp 224", blocked_mask); miscompares++; end
    vectors++;
    if (event_count !== 8'(exp_events)) begin $display("FAIL multi.events got %0d exp %0d", event_count, exp_events); miscompares++; end
    vectors++;
    if (rif.rpt_valid !== 1'b1 || rif.rpt_chan !== 4'd2 || rif.rpt_last !== 1'b0) begin
      $display("FAIL multi.beat0 got v%0b c%0d l%0b exp v1 c2 l0", rif.rpt_valid, rif.rpt_chan, rif.rpt_last); miscompares++;
    end
    vectors++;
    step();
    if (rif.rpt_valid !== 1'b1 || rif.rpt_chan !== 4'd5 || rif.rpt_last !== 1'b0) begin
      $display("FAIL multi.beat1 got v%0b c%0d l%0b exp v1 c5 l0", rif.rpt_valid, rif.rpt_chan, rif.rpt_last); miscompares++;
    end
    vectors++;
    step();
    if (rif.rpt_valid !== 1'b1 || rif.rpt_chan !== 4'd9 || rif.rpt_last !== 1'b1) begin
      $display("FAIL multi.beat2 got v%0b c%0d l%0b exp v1 c9 l1", rif.rpt_valid, rif.rpt_chan, rif.rpt_last); miscompares++;
    end
    vectors++;
    step();
    if (rif.rpt_valid !== 1'b0 || deadlock !== 1'b1 || blocked_mask !== 10'h224) begin
      $display("FAIL multi.hold got v%0b d%0b m%h exp v0 d1 m224", rif.rpt_valid, deadlock, blocked_mask); miscompares++;
    end
    vectors++;
    enable = 1'b0;
    step();
    enable = 1'b1;
    if (deadlock !== 1'b1 || rif.rpt_valid !== 1'b0) begin
      $display("FAIL multi.hold2 got d%0b v%0b exp d1 v0", deadlock, rif.rpt_valid); miscompares++;
    end
    vectors++;
    pulse_clear();
    if (deadlock !== 1'b0 || blocked_mask !== 10'h000) begin
      $display("FAIL multi.clear got d%0b m%h exp d0 m000", deadlock, blocked_mask); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_backpressure();
    rif.rpt_ready = 1'b0;
    detect(info_259);
    if (rif.rpt_valid !== 1'b1 || rif.rpt_chan !== 4'd2 || rif.rpt_last !== 1'b0) begin
      $display("FAIL bp.first got v%0b c%0d l%0b exp v1 c2 l0", rif.rpt_valid, rif.rpt_chan, rif.rpt_last); miscompares++;
    end
    vectors++;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (rif.rpt_valid !== 1'b1 || rif.rpt_chan !== 4'd2 || rif.rpt_last !== 1'b0) begin
        $display("FAIL bp.stall%0d got v%0b c%0d l%0b exp v1 c2 l0", k, rif.rpt_valid, rif.rpt_chan, rif.rpt_last); miscompares++;
      end
      vectors++;
    end
    rif.rpt_ready = 1'b1;
    step();
    if (rif.rpt_chan !== 4'd5 || rif.rpt_last !== 1'b0) begin
      $display("FAIL bp.beat1 got c%0d l%0b exp c5 l0", rif.rpt_chan, rif.rpt_last); miscompares++;
    end
    vectors++;
    step();
    if (rif.rpt_chan !== 4'd9 || rif.rpt_last !== 1'b1) begin
      $display("FAIL bp.beat2 got c%0d l%0b exp c9 l1", rif.rpt_chan, rif.rpt_last); miscompares++;
    end
    vectors++;
    step();
    if (rif.rpt_valid !== 1'b0 || deadlock !== 1'b1) begin
      $display("FAIL bp.hold got v%0b d%0b exp v0 d1", rif.rpt_valid, deadlock); miscompares++;
    end
    vectors++;
    pulse_clear();
  endtask

  task automatic test_empty_snapshot();
    rif.rpt_ready = 1'b1;
    detect('0);
    if (rif.rpt_valid !== 1'b1 || rif.rpt_chan !== 4'd10 || rif.rpt_last !== 1'b1) begin
      $display("FAIL empty.beat got v%0b c%0d l%0b exp v1 c10 l1", rif.rpt_valid, rif.rpt_chan, rif.rpt_last); miscompares++;
    end
    vectors++;
    if (blocked_mask !== 10'h000 || deadlock !== 1'b1) begin
      $display("FAIL empty.state got m%h d%0b exp m000 d1", blocked_mask, deadlock); miscompares++;
    end
    vectors++;
    step();
    if (rif.rpt_valid !== 1'b0 || deadlock !== 1'b1) begin
      $display("FAIL empty.hold got v%0b d%0b exp v0 d1", rif.rpt_valid, deadlock); miscompares++;
    end
    vectors++;
    pulse_clear();
  endtask

  task automatic test_abort();
    rif.rpt_ready = 1'b1;
    detect(info_259);
    step();
    if (rif.rpt_chan !== 4'd5) begin $display("FAIL abort.beat1 got %0d exp 5", rif.rpt_chan); miscompares++; end
    vectors++;
    pulse_clear();
    if (rif.rpt_valid !== 1'b0 || deadlock !== 1'b0 || blocked_mask !== 10'h000) begin
      $display("FAIL abort.cleared got v%0b d%0b m%h exp v0 d0 m000", rif.rpt_valid, deadlock, blocked_mask); miscompares++;
    end
    vectors++;
    step();
    if (rif.rpt_valid !== 1'b0) begin $display("FAIL abort.nobeat got %0b exp 0", rif.rpt_valid); miscompares++; end
    vectors++;
    detect(info_259);
    if (event_count !== 8'(exp_events) || deadlock !== 1'b1) begin
      $display("FAIL abort.redetect got e%0d d%0b exp e%0d d1", event_count, deadlock, exp_events); miscompares++;
    end
    vectors++;
    pulse_clear();
  endtask

  task automatic test_saturation_reset();
    rif.rpt_ready = 1'b1;
    repeat (260) begin
      detect(info_259);
      pulse_clear();
    end
    if (event_count !== 8'd255) begin $display("FAIL sat.events got %0d exp 255", event_count); miscompares++; end
    vectors++;
    rif.rpt_ready = 1'b0;
    detect(info_259);
    if (event_count !== 8'd255 || rif.rpt_valid !== 1'b1) begin
      $display("FAIL sat.hold got e%0d v%0b exp e255 v1", event_count, rif.rpt_valid); miscompares++;
    end
    vectors++;
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_events = 0;
    if (deadlock !== 1'b0 || blocked_mask !== 10'h000 || rif.rpt_valid !== 1'b0 ||
        rif.rpt_chan !== 4'd0 || rif.rpt_last !== 1'b0 || event_count !== 8'd0) begin
      $display("FAIL midrpt_reset got d%0b m%h v%0b c%0d l%0b e%0d exp all 0",
               deadlock, blocked_mask, rif.rpt_valid, rif.rpt_chan, rif.rpt_last, event_count); miscompares++;
    end
    vectors++;
    step();
    if (rif.rpt_valid !== 1'b0 || event_count !== 8'd0) begin
      $display("FAIL postreset got v%0b e%0d exp v0 e0", rif.rpt_valid, event_count); miscompares++;
    end
    vectors++;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    exp_events    = 0;
    reset         = 1'b0;
    enable        = 1'b0;
    block_in      = 1'b0;
    block_info_in = '0;
    clear         = 1'b0;
    rif.rpt_ready = 1'b0;
    info_259      = '0;
    info_259[2*NUM_CH + 3] = 1'b1;
    info_259[5*NUM_CH + 0] = 1'b1;
    info_259[5*NUM_CH + 7] = 1'b1;
    info_259[9*NUM_CH + 9] = 1'b1;

    test_reset();
    test_persistence();
    test_clear_priority();
    test_multi_channel();
    test_backpressure();
    test_empty_snapshot();
    test_abort();
    test_saturation_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
